// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store controller: decodes the access, runs a single-outstanding
// request/response handshake on a simple bus, and returns extended load data.
module data_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallMem,
  output logic [31:0] ReadDataM,
  output logic        misalign,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              fault_flag_q, fault_flag_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic        size_legal, aligned, accept;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // funct3[1:0] encodes size (00 byte, 01 half, 10 word); bit 2 is unsigned, loads only.
  always_comb begin
    size_legal = (funct3[1:0] != 2'b11) &&
                 (MemWrite ? !funct3[2] : !(funct3[2] && funct3[1:0] == 2'b10));
    unique case (funct3[1:0])
      2'b01:   aligned = !ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept = (state_q == IDLE) && mem_en && size_legal && aligned;
  end

  always_comb begin
    unique case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << ALUResultM[1:0];
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
      end
    endcase
  end

  always_comb begin
    lane_b = bus_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'h0, lane_b};
      3'b101:  load_val = {16'h0, lane_h};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case leaves a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    fault_flag_d = fault_flag_q;
    rdata_d      = rdata_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          we_d        = MemWrite;
          f3_d        = funct3;
          off_d       = ALUResultM[1:0];
          bus_addr_d  = {ALUResultM[31:2], 2'b00};
          bus_be_d    = be_new;
          bus_wdata_d = wdata_new;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus_rvalid) begin
          fault_flag_d = bus_err;
          if (!we_q && !bus_err) rdata_d = load_val;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          fault_flag_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      fault_flag_q <= 1'b0;
      rdata_q      <= '0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      fault_flag_q <= fault_flag_d;
      rdata_q      <= rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  // Control outputs decode straight from state, so reset drops them without waiting for a clock.
  assign StallMem  = accept || (state_q == REQ) || (state_q == RESP);
  assign misalign  = (state_q == IDLE) && mem_en && !(size_legal && aligned);
  assign fault     = (state_q == DONE) && fault_flag_q;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = (state_q == REQ) && we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized accesses
// compared against an arithmetic model of the load/store rules.
module tb_data_mem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallMem, misalign, fault;
  logic [31:0] ReadDataM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;

  data_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .MemWrite(MemWrite), .funct3(funct3),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallMem(StallMem),
    .ReadDataM(ReadDataM), .misalign(misalign), .fault(fault), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 when the code is not a legal access of this direction.
  function automatic int size_of(input bit we, input logic [2:0] f3);
    int sz;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    if (f3[2] && (we || sz == 4)) sz = 0;
    return sz;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int lane;
    lane = int'(addr % 4);
    case (f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * lane)) % 256;
        if (f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * (lane / 2))) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One complete access; gnt arrives after gnt_dly REQ cycles, rvalid in RESP cycle rv_dly
  // (rv_dly >= TIMEOUT means never).
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                        input bit err, input logic [31:0] rd);
    int sz, n;
    bit ok, tmo;
    logic [31:0] e_be, e_wd, v;
    sz = size_of(we, f3);
    ok = (sz != 0) && ((addr % sz) == 0);
    @(negedge clk);
    mem_en = 1'b1; MemWrite = we; funct3 = f3; ALUResultM = addr; WriteDataM = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    #1;
    check("stall_accept", StallMem, ok);
    check("misalign", misalign, !ok);
    check("req_idle", bus_req, 0);
    if (!ok) begin
      @(posedge clk);
      @(negedge clk);
      mem_en = 1'b0;
      #1;
      check("misalign_once", misalign, 0);
      check("stall_after_misalign", StallMem, 0);
      check("req_after_misalign", bus_req, 0);
      return;
    end
    if (sz == 1) begin
      e_be = 32'(1) << (addr % 4);
      e_wd = (wd % 256) * 32'h0101_0101;
    end else if (sz == 2) begin
      e_be = 32'(3) << (2 * ((addr % 4) / 2));
      e_wd = (wd % 65536) * 32'h0001_0001;
    end else begin
      e_be = 32'hF;
      e_wd = wd;
    end
    @(posedge clk);
    for (int i = 0; i <= gnt_dly; i++) begin
      @(negedge clk);
      mem_en = 1'b0; MemWrite = $urandom % 2; ALUResultM = $urandom; WriteDataM = $urandom;
      bus_gnt = (i == gnt_dly); bus_rvalid = $urandom % 2; bus_rdata = $urandom;
      #1;
      check("req_req", bus_req, 1);
      check("req_stall", StallMem, 1);
      check("req_we", bus_we, we);
      check("req_addr", bus_addr, addr - (addr % 4));
      check("req_be", bus_be, e_be);
      check("req_wdata", bus_wdata, we ? e_wd : bus_wdata);
      @(posedge clk);
    end
    tmo = (rv_dly >= TIMEOUT);
    n = tmo ? TIMEOUT : rv_dly + 1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus_gnt = $urandom % 2;
      bus_rvalid = (k == rv_dly);
      bus_err = (k == rv_dly) ? err : 1'($urandom % 2);
      bus_rdata = (k == rv_dly) ? rd : $urandom;
      #1;
      check("resp_req", bus_req, 0);
      check("resp_stall", StallMem, 1);
      check("resp_fault", fault, 0);
      @(posedge clk);
    end
    if (!we && !tmo && !err) exp_rd = load_model(f3, addr, rd);
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = $urandom % 2; bus_err = 1'b0; bus_rdata = $urandom;
    #1;
    check("done_stall", StallMem, 0);
    check("done_fault", fault, tmo || err);
    check("done_req", bus_req, 0);
    v = ReadDataM;
    check("done_rdata", v, exp_rd);
    @(posedge clk);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("idle_fault", fault, 0);
    check("idle_stall", StallMem, 0);
  endtask

  initial begin
    reset = 1'b0; mem_en = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResultM = '0; WriteDataM = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_err = 1'b0; bus_rdata = '0;
    #12;
    check("rst_stall", StallMem, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_fault", fault, 0);
    check("rst_misalign", misalign, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed scenarios.
    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
    check("lw_rdata", exp_rd, 32'hDEAD_BEEF);
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0, 32'h80AA_BBCC);
    check("lb_rdata", ReadDataM, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 1, 2, 1'b0, 32'h80AA_BBCC);
    check("lbu_rdata", ReadDataM, 32'h0000_0080);
    access(1'b1, 3'b001, 32'h202, 32'h0000_1234, 0, 0, 1'b0, 32'hFFFF_FFFF);
    check("sh_keep_rdata", ReadDataM, 32'h0000_0080);
    access(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0);
    access(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);
    access(1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);
    access(1'b0, 3'b010, 32'h300, 32'h0, 0, TIMEOUT + 4, 1'b0, 32'h0);
    check("tmo_keep_rdata", ReadDataM, 32'h0000_0080);
    access(1'b0, 3'b010, 32'h300, 32'h0, 2, 3, 1'b1, 32'h5555_5555);
    check("err_keep_rdata", ReadDataM, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h302, 32'h0, 0, 0, 1'b0, 32'h9876_0000);
    access(1'b0, 3'b101, 32'h300, 32'h0, 0, TIMEOUT - 1, 1'b0, 32'h0000_8001);

    // Randomized accesses against the model.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      bit w;
      int rvd;
      w = $urandom % 2;
      a = $urandom;
      if ($urandom % 3 != 0) a = a - (a % 4);
      rvd = ($urandom % 8 == 0) ? TIMEOUT + 3 : int'($urandom % 4);
      access(w, 3'($urandom % 8), a, $urandom, int'($urandom % 4), rvd,
             ($urandom % 8) == 0, $urandom);
    end

    // Asynchronous reset in the middle of RESP, then a stray response.
    @(negedge clk);
    mem_en = 1'b1; MemWrite = 1'b1; funct3 = 3'b010; ALUResultM = 32'h40; WriteDataM = 32'hA5A5_A5A5;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    mem_en = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    check("pre_rst_stall", StallMem, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_stall", StallMem, 0);
    check("arst_req", bus_req, 0);
    check("arst_we", bus_we, 0);
    check("arst_fault", fault, 0);
    check("arst_misalign", misalign, 0);
    check("arst_addr", bus_addr, 0);
    check("arst_be", bus_be, 0);
    check("arst_wdata", bus_wdata, 0);
    check("arst_rdata", ReadDataM, 0);
    exp_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678; bus_err = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("stray_stall", StallMem, 0);
    check("stray_req", bus_req, 0);
    check("stray_fault", fault, 0);
    check("stray_rdata", ReadDataM, exp_rd);
    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent in RESP waiting for bus_rvalid.
REQ-002 Ports SHALL be:
- clk  in  1  — the single clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-low.
- mem_en  in  1  — the MEM-stage instruction is a load or store.
- MemWrite  in  1  — 1 = store, 0 = load.
- funct3  in  3  — access size and sign.
- ALUResultM  in  32  — byte address.
- WriteDataM  in  32  — store data.
- StallMem  out  1  — freezes the pipeline.
- ReadDataM  out  32  — extended load result.
- misalign  out  1  — one-cycle alignment/illegal-size exception pulse.
- fault  out  1  — one-cycle bus error/timeout pulse.
- bus_req  out  1  — bus request.
- bus_we  out  1  — bus write enable.
- bus_addr  out  32  — word-aligned bus address.
- bus_be  out  4  — byte enables.
- bus_wdata  out  32  — bus write data.
- bus_gnt  in  1  — request accepted.
- bus_rvalid  in  1  — response/ack valid.
- bus_rdata  in  32  — read data.
- bus_err  in  1  — error, qualified by bus_rvalid.

Function
REQ-003 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-004 Legal funct3 SHALL be:
- loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu;
- stores: 000 sb, 001 sh, 010 sw.
All other codes are illegal.
REQ-005 Misaligned access SHALL be: halfword with addr[0]=1, or word with addr[1:0]≠00.
REQ-006 IDLE with mem_en=1 and access legal+aligned SHALL latch address/data/size/MemWrite, assert StallMem combinationally that cycle, and go to REQ.
REQ-007 IDLE with mem_en=1 and access illegal or misaligned SHALL pulse misalign for that cycle, keep StallMem=0, issue no bus request, and stay in IDLE.
REQ-008 In REQ, bus_req SHALL be 1 with bus_we/bus_addr/bus_be/bus_wdata stable from the latched values; bus_gnt=1 → RESP; otherwise remain in REQ indefinitely.
REQ-009 bus_addr SHALL equal {addr[31:2],2'b00}.
REQ-010 Byte enables and write data SHALL be:
- byte: bus_be = 0001<<addr[1:0], bus_wdata = byte replicated ×4;
- half: bus_be = 0011<<(2·addr[1]), bus_wdata = half replicated ×2;
- word: bus_be = 1111.
REQ-011 In RESP, bus_req SHALL be 0 and a cycle counter SHALL increment from 0.
- bus_rvalid=1 → DONE.
- Counter reaching TIMEOUT-1 without rvalid → DONE, flagged as timeout.
REQ-012 On bus_rvalid=1 with bus_err=0 for a load, ReadDataM SHALL register the selected byte/half/word of bus_rdata, sign-extended for lb/lh and zero-extended for lbu/lhu; lane is chosen by addr[1:0].
REQ-013 ReadDataM SHALL hold its value until the next successful load and SHALL be unchanged by stores, errors, and timeouts.
REQ-014 In DONE, StallMem SHALL be 0 for exactly one cycle, fault SHALL be 1 if bus_err or timeout occurred, and the FSM SHALL go to IDLE next cycle.
REQ-015 StallMem SHALL be 1 in REQ and RESP, and in IDLE only per REQ-006.
REQ-016 Minimum latency SHALL be 3 cycles from acceptance in IDLE to DONE: gnt in the first REQ cycle, rvalid in the first RESP cycle.
REQ-017 bus_rvalid outside RESP SHALL be ignored; bus_gnt outside REQ SHALL be ignored.
REQ-018 A store SHALL complete only on bus_rvalid (write ack), the same as a load.

Reset
REQ-019 reset=0 SHALL asynchronously force:
- state IDLE, counter 0;
- StallMem, bus_req, bus_we, misalign, fault all 0;
- bus_addr, bus_be, bus_wdata, ReadDataM all 0.
REQ-020 Reset asserted in REQ or RESP SHALL drop bus_req immediately and abandon the access; a late bus_rvalid after reset release SHALL be ignored per REQ-017.

Verification
REQ-021 lw @0x100, gnt and rvalid immediate, rdata=0xDEADBEEF → ReadDataM=0xDEADBEEF, StallMem high 3 cycles then low 1 cycle (DONE).
REQ-022 lb @0x103, rdata=0x80AABBCC → bus_be=1000, ReadDataM=0xFFFFFF80; same access with lbu → ReadDataM=0x00000080.
REQ-023 sh @0x202, WriteDataM=0x00001234 → bus_addr=0x200, bus_be=1100, bus_wdata=0x12341234, bus_we=1, ReadDataM unchanged.
REQ-024 lw @0x101 → misalign=1 for one cycle, bus_req never asserted, StallMem=0; funct3=011 → same response.
REQ-025 TIMEOUT=16, lw, gnt given, rvalid never → fault=1 in DONE after 16 RESP cycles, ReadDataM unchanged; rvalid with bus_err=1 → same fault response.
REQ-026 reset=0 mid-RESP → all outputs 0 asynchronously; after release, a stray bus_rvalid leaves state IDLE and ReadDataM=0.
